// File: rtl/recirc_pipe_n_pkg.sv
// rtl/recirc_pipe_n_pkg.sv - shared FSM encoding, debounce limits and lane slice helper
package recirc_pipe_n_pkg;

  typedef enum logic [1:0] {
    ST_RCIRC = 2'd0,
    ST_ARM   = 2'd1,
    ST_FWD   = 2'd2
  } state_t;

  // Legal range of the idle debounce length (fits the 4-bit idle counter).
  localparam int IDLE_CYC_MIN = 1;
  localparam int IDLE_CYC_MAX = 15;

  // Low bit index of lane k inside a packed multi-lane bus of width w per lane.
  function automatic int lane_lsb(input int k, input int w);
    return k * w;
  endfunction

endpackage

// File: rtl/recirc_lane.sv
// rtl/recirc_lane.sv - one lane: stage-1 flop, route mux, stage-2 flop, forwarded-word counter
//
// Ports:
//   clk_f, reset        block clock, synchronous active-high reset
//   fwd                 1 = route stage-1 word forward, 0 = recirculate
//   cnt_clr             synchronous clear of the forwarded-word counter
//   data_in, valid_in   lane input word
//   data_out, valid_out forwarded word (registered, stage 2)
//   data_rc, valid_rc   recirculated word (combinational from stage 1)
//   fwd_cnt             count of valid words loaded into stage 2
module recirc_lane
  import recirc_pipe_n_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int CNT_W  = 8
) (
  input  logic              clk_f,
  input  logic              reset,
  input  logic              fwd,
  input  logic              cnt_clr,
  input  logic [DATA_W-1:0] data_in,
  input  logic              valid_in,
  output logic [DATA_W-1:0] data_out,
  output logic              valid_out,
  output logic [DATA_W-1:0] data_rc,
  output logic              valid_rc,
  output logic [CNT_W-1:0]  fwd_cnt
);

  logic [DATA_W-1:0] s1_data;
  logic              s1_valid;
  logic [DATA_W-1:0] fwd_data;
  logic              fwd_valid;

  // Data is masked to zero on whichever path does not own the word, and
  // whenever the word itself is invalid.
  always_comb begin
    fwd_valid = fwd & s1_valid;
    fwd_data  = fwd_valid ? s1_data : '0;
    valid_rc  = ~fwd & s1_valid;
    data_rc   = valid_rc ? s1_data : '0;
  end

  always_ff @(posedge clk_f) begin
    if (reset) begin
      s1_data   <= '0;
      s1_valid  <= 1'b0;
      data_out  <= '0;
      valid_out <= 1'b0;
      fwd_cnt   <= '0;
    end else begin
      s1_data   <= data_in;
      s1_valid  <= valid_in;
      data_out  <= fwd_data;
      valid_out <= fwd_valid;
      // Clear beats a simultaneous increment.
      if (cnt_clr) begin
        fwd_cnt <= '0;
      end else if (fwd_valid) begin
        fwd_cnt <= fwd_cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/recirc_pipe_n.sv
// rtl/recirc_pipe_n.sv - N-lane flop/recirculate/flop block with debounced idle-detect routing
//
// Ports:
//   clk_f, reset        block clock, synchronous active-high reset
//   data_in, valid_in   lane k at data_in[k*DATA_W +: DATA_W], valid_in[k]
//   idle_out            upstream FIFO idle indication (debounced here)
//   cnt_clr             synchronous clear of all forwarded-word counters
//   data_out, valid_out forwarded words, 2-cycle latency
//   data_rc, valid_rc   recirculated words, 1-cycle latency
//   fwd_active          registered, high while the FSM is in FWD
//   fwd_cnt             per-lane forwarded-word counters, lane k at [k*CNT_W +: CNT_W]
module recirc_pipe_n
  import recirc_pipe_n_pkg::*;
#(
  parameter int NLANES   = 4,
  parameter int DATA_W   = 8,
  parameter int IDLE_CYC = 2,
  parameter int CNT_W    = 8
) (
  input  logic                     clk_f,
  input  logic                     reset,
  input  logic [NLANES*DATA_W-1:0] data_in,
  input  logic [NLANES-1:0]        valid_in,
  input  logic                     idle_out,
  input  logic                     cnt_clr,
  output logic [NLANES*DATA_W-1:0] data_out,
  output logic [NLANES-1:0]        valid_out,
  output logic [NLANES*DATA_W-1:0] data_rc,
  output logic [NLANES-1:0]        valid_rc,
  output logic                     fwd_active,
  output logic [NLANES*CNT_W-1:0]  fwd_cnt
);

  // Out-of-range debounce lengths are clamped so the 4-bit counter always
  // has a reachable target.
  localparam int IDLE_CLAMP = (IDLE_CYC < IDLE_CYC_MIN) ? IDLE_CYC_MIN :
                              (IDLE_CYC > IDLE_CYC_MAX) ? IDLE_CYC_MAX : IDLE_CYC;
  localparam logic [3:0] IDLE_TGT = 4'(IDLE_CLAMP);

  state_t     state;
  logic [3:0] idle_cnt;
  logic       fwd;

  // Routing follows the registered state, so a word in stage 1 on the edge
  // that leaves FWD is still forwarded.
  assign fwd = (state == ST_FWD);

  always_ff @(posedge clk_f) begin
    if (reset) begin
      state      <= ST_RCIRC;
      idle_cnt   <= 4'd0;
      fwd_active <= 1'b0;
    end else begin
      case (state)
        ST_RCIRC: begin
          if (idle_out && IDLE_TGT == 4'd1) begin
            state      <= ST_FWD;
            idle_cnt   <= 4'd1;
            fwd_active <= 1'b1;
          end else if (idle_out) begin
            state      <= ST_ARM;
            idle_cnt   <= 4'd1;
            fwd_active <= 1'b0;
          end else begin
            idle_cnt   <= 4'd0;
            fwd_active <= 1'b0;
          end
        end
        ST_ARM: begin
          if (!idle_out) begin
            state      <= ST_RCIRC;
            idle_cnt   <= 4'd0;
            fwd_active <= 1'b0;
          end else begin
            idle_cnt <= idle_cnt + 4'd1;
            if (idle_cnt + 4'd1 == IDLE_TGT) begin
              state      <= ST_FWD;
              fwd_active <= 1'b1;
            end else begin
              fwd_active <= 1'b0;
            end
          end
        end
        ST_FWD: begin
          if (!idle_out) begin
            state      <= ST_RCIRC;
            idle_cnt   <= 4'd0;
            fwd_active <= 1'b0;
          end else begin
            fwd_active <= 1'b1;
          end
        end
        default: begin
          state      <= ST_RCIRC;
          idle_cnt   <= 4'd0;
          fwd_active <= 1'b0;
        end
      endcase
    end
  end

  for (genvar k = 0; k < NLANES; k++) begin : g_lane
    localparam int DLSB = lane_lsb(k, DATA_W);
    localparam int CLSB = lane_lsb(k, CNT_W);

    recirc_lane #(
      .DATA_W (DATA_W),
      .CNT_W  (CNT_W)
    ) u_lane (
      .clk_f     (clk_f),
      .reset     (reset),
      .fwd       (fwd),
      .cnt_clr   (cnt_clr),
      .data_in   (data_in[DLSB +: DATA_W]),
      .valid_in  (valid_in[k]),
      .data_out  (data_out[DLSB +: DATA_W]),
      .valid_out (valid_out[k]),
      .data_rc   (data_rc[DLSB +: DATA_W]),
      .valid_rc  (valid_rc[k]),
      .fwd_cnt   (fwd_cnt[CLSB +: CNT_W])
    );
  end

endmodule
